// File: rtl/regbank_wrctl_pkg.sv
// ============================================================================
// Module   : regbank_wrctl_pkg
// Purpose  : Shared definitions for the 8085 register-bank write controller:
//            register codes, register-pair codes, FSM state encodings and
//            the address-validity rule.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package regbank_wrctl_pkg;

  // Register codes as used in 8085 opcodes; M (6) is memory, not a register
  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_M = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  // Pair codes name the high register of each pair
  localparam logic [2:0] PAIR_BC = 3'd0;
  localparam logic [2:0] PAIR_DE = 3'd2;
  localparam logic [2:0] PAIR_HL = 3'd4;

  // Write-controller FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR1  = 2'd1;
  localparam logic [1:0] ST_WR2  = 2'd2;

  // A byte write may target any register except M; a pair write must name BC/DE/HL
  function automatic logic addr_ok(input logic pair, input logic [2:0] addr);
    if (pair) begin
      return (addr == PAIR_BC) || (addr == PAIR_DE) || (addr == PAIR_HL);
    end
    return addr != REG_M;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_rr2.sv
// ============================================================================
// Module   : arbiter_rr2
// Purpose  : Two-way round-robin arbiter. Grant is combinational from the
//            request vector and a last-served pointer; the pointer moves only
//            when the grant is actually taken (adv).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module arbiter_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // last_one=1 means requester 1 was served last, so requester 0 wins a tie
  logic last_one;

  // Tie goes to whichever requester was not served last
  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = last_one ? 2'b01 : 2'b10;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  // Remember who was served; reset favours requester 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_one <= 1'b1;
    end else if (adv && (gnt != 2'b00)) begin
      last_one <= gnt[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/regbank_wrctl.sv
// ============================================================================
// Module   : regbank_wrctl
// Purpose  : Write-port controller for the 8085 register bank. Arbitrates the
//            single write path between two requesters and drives one-hot
//            register enables plus shared write data. 16-bit pair writes are
//            split into high byte then low byte.
// Config   : REGCTL_PAIR_EN defined enables pair writes; undefined makes every
//            request a byte write and wide0/wide1 are ignored.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regbank_wrctl
  import regbank_wrctl_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    wide0,
  input  logic [ADDRSIZE-1:0]     addr0,
  input  logic [2*DATASIZE-1:0]   data0,
  input  logic                    req1,
  input  logic                    wide1,
  input  logic [ADDRSIZE-1:0]     addr1,
  input  logic [2*DATASIZE-1:0]   data1,
  output logic                    ack0,
  output logic                    ack1,
  output logic                    err,
  output logic                    busy,
  output logic [2**ADDRSIZE-1:0]  enb,
  output logic [DATASIZE-1:0]     wdata
);

  localparam int NREG = 2**ADDRSIZE;

  logic [1:0]            state;
  logic [1:0]            gnt;
  logic                  start;
  logic                  req_pair;
  logic                  req_ok;
  logic [ADDRSIZE-1:0]   req_addr;
  logic [2*DATASIZE-1:0] req_data;

  // Latched copy of the granted request, needed only for the second pair beat
  logic                  lat_sel;
  logic                  lat_two;
  logic [ADDRSIZE-1:0]   lat_addr;
  logic [DATASIZE-1:0]   lat_lo;

  assign start = (state == ST_IDLE) && (gnt != 2'b00);

  arbiter_rr2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1, req0}),
    .adv (start),
    .gnt (gnt)
  );

  // Select the granted requester's fields
  always_comb begin
    req_addr = gnt[1] ? addr1 : addr0;
    req_data = gnt[1] ? data1 : data0;
  end

`ifdef REGCTL_PAIR_EN
  assign req_pair = gnt[1] ? wide1 : wide0;
`else
  assign req_pair = 1'b0;
  wire unused_wide = &{1'b0, wide0, wide1};
`endif

  assign req_ok = addr_ok(req_pair, 3'(req_addr));

  // FSM with registered outputs: each edge loads the outputs of the state being entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      enb      <= '0;
      wdata    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      lat_sel  <= 1'b0;
      lat_two  <= 1'b0;
      lat_addr <= '0;
      lat_lo   <= '0;
    end else begin
      enb   <= '0;
      wdata <= '0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_WR1;
            busy     <= 1'b1;
            lat_sel  <= gnt[1];
            lat_two  <= req_pair && req_ok;
            lat_addr <= req_addr;
            lat_lo   <= req_data[DATASIZE-1:0];
            enb      <= req_ok ? (NREG'(1) << req_addr) : '0;
            wdata    <= req_pair ? req_data[2*DATASIZE-1:DATASIZE]
                                 : req_data[DATASIZE-1:0];
            // Byte writes and rejected requests finish in this single beat
            if (!(req_pair && req_ok)) begin
              ack0 <= ~gnt[1];
              ack1 <= gnt[1];
              err  <= ~req_ok;
            end
          end
        end
        ST_WR1: begin
          if (lat_two) begin
            state <= ST_WR2;
            busy  <= 1'b1;
            enb   <= NREG'(2) << lat_addr;
            wdata <= lat_lo;
            ack0  <= ~lat_sel;
            ack1  <= lat_sel;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WR2:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
